// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register addresses, exception codes, field positions and write masks.
package cp0_pkg;

  localparam logic [4:0] ADDR_INDEX    = 5'd0;
  localparam logic [4:0] ADDR_ENTRYLO0 = 5'd2;
  localparam logic [4:0] ADDR_ENTRYLO1 = 5'd3;
  localparam logic [4:0] ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] ADDR_COUNT    = 5'd9;
  localparam logic [4:0] ADDR_ENTRYHI  = 5'd10;
  localparam logic [4:0] ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] ADDR_STATUS   = 5'd12;
  localparam logic [4:0] ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] ADDR_EPC      = 5'd14;
  localparam logic [4:0] ADDR_PRID     = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE     = 0;
  localparam int ST_EXL    = 1;
  localparam int ST_IM_LO  = 8;
  localparam int ST_BEV    = 22;
  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;
  localparam int IDX_P     = 31;

  localparam logic [31:0] MASK_STATUS  = 32'h0000_FF03;
  localparam logic [31:0] MASK_ENTRYHI = 32'hFFFF_E0FF;
  localparam logic [31:0] MASK_ENTRYLO = 32'h03FF_FFFF;
  localparam logic [31:0] STATUS_BEV   = 32'h0040_0000;

  // Address-related exceptions latch the faulting address into BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code >= EXC_MOD) && (code <= EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// rtl/cp0_timer.sv - Count prescaler, Count/Compare registers and sticky timer interrupt.
module cp0_timer import cp0_pkg::*; #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  localparam logic [2:0] PHASE_LAST = 3'(COUNT_DIV - 1);

  logic [2:0] phase;
  logic       fresh;  // count holds a value produced by an increment this cycle

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase   <= 3'd0;
      count   <= 32'd0;
      compare <= 32'd0;
      ti      <= 1'b0;
      fresh   <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        phase <= 3'd0;
        fresh <= 1'b0;
      end else if (phase == PHASE_LAST) begin
        count <= count + 32'd1;
        phase <= 3'd0;
        fresh <= 1'b1;
      end else begin
        phase <= phase + 3'd1;
        fresh <= 1'b0;
      end
      // A Compare write clears TI even if a match lands on the same edge.
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (fresh && (count == compare)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_ext.sv
// rtl/cp0_ext.sv - CP0 register file: Status/Cause/EPC/BadVAddr, TLB support registers, timer.
module cp0_ext import cp0_pkg::*; #(
  parameter int          HW_INT_W    = 6,
  parameter int          COUNT_DIV   = 2,
  parameter int          TLB_ENTRIES = 16,
  parameter logic [31:0] PRID_VAL    = 32'h004C_0102
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we_i,
  input  logic [4:0]                     waddr_i,
  input  logic [31:0]                    wdata_i,
  input  logic [4:0]                     raddr_i,
  output logic [31:0]                    rdata_o,
  input  logic [HW_INT_W-1:0]            hw_int_i,
  input  logic                           exc_valid_i,
  input  logic [4:0]                     exc_code_i,
  input  logic [31:0]                    exc_pc_i,
  input  logic                           exc_bd_i,
  input  logic [31:0]                    exc_badvaddr_i,
  input  logic                           eret_i,
  input  logic                           tlbp_i,
  input  logic                           tlbp_hit_i,
  input  logic [$clog2(TLB_ENTRIES)-1:0] tlbp_idx_i,
  input  logic                           tlbr_i,
  input  logic [31:0]                    tlbr_hi_i,
  input  logic [31:0]                    tlbr_lo0_i,
  input  logic [31:0]                    tlbr_lo1_i,
  output logic [31:0]                    status_o,
  output logic [31:0]                    cause_o,
  output logic [31:0]                    epc_o,
  output logic [31:0]                    index_o,
  output logic [31:0]                    entryhi_o,
  output logic [31:0]                    entrylo0_o,
  output logic [31:0]                    entrylo1_o,
  output logic                           timer_int_o,
  output logic                           int_req_o
);

  localparam int IDX_W = $clog2(TLB_ENTRIES);

  logic [31:0]      status_q, status_n, epc_q, epc_n, badvaddr_q, badvaddr_n;
  logic [31:0]      entryhi_q, entryhi_n, entrylo0_q, entrylo0_n, entrylo1_q, entrylo1_n;
  logic             bd_q, bd_n, idx_p_q, idx_p_n;
  logic [4:0]       exc_code_q, exc_code_n;
  logic [1:0]       sw_ip_q, sw_ip_n;
  logic [5:0]       hw_ip_q;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic [7:0]       ip;
  logic [31:0]      count, compare, rd;
  logic             ti;

  logic wr_index, wr_lo0, wr_lo1, wr_hi, wr_status, wr_cause, wr_epc;
  assign wr_index  = we_i && (waddr_i == ADDR_INDEX);
  assign wr_lo0    = we_i && (waddr_i == ADDR_ENTRYLO0);
  assign wr_lo1    = we_i && (waddr_i == ADDR_ENTRYLO1);
  assign wr_hi     = we_i && (waddr_i == ADDR_ENTRYHI);
  assign wr_status = we_i && (waddr_i == ADDR_STATUS);
  assign wr_cause  = we_i && (waddr_i == ADDR_CAUSE);
  assign wr_epc    = we_i && (waddr_i == ADDR_EPC);

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (we_i && (waddr_i == ADDR_COUNT)),
    .compare_we (we_i && (waddr_i == ADDR_COMPARE)),
    .wdata      (wdata_i),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );

  // Later assignments win: exception > ERET > TLBP/TLBR > MTC0.
  always_comb begin
    status_n   = status_q;
    bd_n       = bd_q;
    exc_code_n = exc_code_q;
    epc_n      = wr_epc ? wdata_i : epc_q;
    badvaddr_n = badvaddr_q;
    sw_ip_n    = wr_cause ? wdata_i[CA_IP_LO +: 2] : sw_ip_q;
    idx_p_n    = idx_p_q;
    idx_n      = wr_index ? wdata_i[IDX_W-1:0] : idx_q;
    entryhi_n  = wr_hi  ? (wdata_i & MASK_ENTRYHI) : entryhi_q;
    entrylo0_n = wr_lo0 ? (wdata_i & MASK_ENTRYLO) : entrylo0_q;
    entrylo1_n = wr_lo1 ? (wdata_i & MASK_ENTRYLO) : entrylo1_q;
    if (wr_status) status_n = wdata_i & MASK_STATUS;
    if (tlbp_i) begin
      idx_p_n = ~tlbp_hit_i;
      if (tlbp_hit_i) idx_n = tlbp_idx_i;
    end
    if (tlbr_i) begin
      entryhi_n  = tlbr_hi_i & MASK_ENTRYHI;
      entrylo0_n = tlbr_lo0_i & MASK_ENTRYLO;
      entrylo1_n = tlbr_lo1_i & MASK_ENTRYLO;
    end
    if (eret_i) status_n[ST_EXL] = 1'b0;
    if (exc_valid_i) begin
      status_n[ST_EXL] = 1'b1;
      exc_code_n       = exc_code_i;
      if (!status_q[ST_EXL]) begin
        bd_n  = exc_bd_i;
        epc_n = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
      end
      if (is_addr_exc(exc_code_i)) badvaddr_n = exc_badvaddr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q   <= 32'd0;
      bd_q       <= 1'b0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
      sw_ip_q    <= 2'd0;
      hw_ip_q    <= 6'd0;
      idx_p_q    <= 1'b0;
      idx_q      <= '0;
      entryhi_q  <= 32'd0;
      entrylo0_q <= 32'd0;
      entrylo1_q <= 32'd0;
    end else begin
      status_q   <= status_n;
      bd_q       <= bd_n;
      exc_code_q <= exc_code_n;
      epc_q      <= epc_n;
      badvaddr_q <= badvaddr_n;
      sw_ip_q    <= sw_ip_n;
      hw_ip_q    <= 6'(hw_int_i);
      idx_p_q    <= idx_p_n;
      idx_q      <= idx_n;
      entryhi_q  <= entryhi_n;
      entrylo0_q <= entrylo0_n;
      entrylo1_q <= entrylo1_n;
    end
  end

  always_comb begin
    ip                      = {hw_ip_q[5] | ti, hw_ip_q[4:0], sw_ip_q};
    status_o                = status_q | STATUS_BEV;
    cause_o                 = 32'd0;
    cause_o[CA_BD]          = bd_q;
    cause_o[CA_TI]          = ti;
    cause_o[CA_IP_LO +: 8]  = ip;
    cause_o[CA_EXC_LO +: 5] = exc_code_q;
    index_o                 = 32'd0;
    index_o[IDX_W-1:0]      = idx_q;
    index_o[IDX_P]          = idx_p_q;
  end

  assign epc_o       = epc_q;
  assign entryhi_o   = entryhi_q;
  assign entrylo0_o  = entrylo0_q;
  assign entrylo1_o  = entrylo1_q;
  assign timer_int_o = ti;
  assign int_req_o   = status_q[ST_IE] & ~status_q[ST_EXL] & (|(ip & status_q[ST_IM_LO +: 8]));

  always_comb begin
    rd = 32'd0;
    case (raddr_i)
      ADDR_INDEX:    rd = index_o;
      ADDR_ENTRYLO0: rd = entrylo0_q;
      ADDR_ENTRYLO1: rd = entrylo1_q;
      ADDR_BADVADDR: rd = badvaddr_q;
      ADDR_COUNT:    rd = count;
      ADDR_ENTRYHI:  rd = entryhi_q;
      ADDR_COMPARE:  rd = compare;
      ADDR_STATUS:   rd = status_o;
      ADDR_CAUSE:    rd = cause_o;
      ADDR_EPC:      rd = epc_q;
      ADDR_PRID:     rd = PRID_VAL;
      default:       rd = 32'd0;
    endcase
  end

  assign rdata_o = rst ? rd : 32'd0;

endmodule

// File: tb/tb_cp0_ext.sv
// tb/tb_cp0_ext.sv - randomized bench for cp0_ext against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_cp0_ext;

  localparam int          HW   = 6;
  localparam int          DIV  = 2;
  localparam int          IDXW = 4;
  localparam logic [31:0] PRID = 32'h004C_0102;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            we;
  logic [4:0]      waddr, raddr, exc_code;
  logic [31:0]     wdata, exc_pc, exc_badvaddr, tlbr_hi, tlbr_lo0, tlbr_lo1;
  logic [HW-1:0]   hw_int;
  logic            exc_valid, exc_bd, eret, tlbp, tlbp_hit, tlbr;
  logic [IDXW-1:0] tlbp_idx;
  logic [31:0]     rdata_o, status_o, cause_o, epc_o, index_o, entryhi_o, entrylo0_o, entrylo1_o;
  logic            timer_int_o, int_req_o;

  cp0_ext #(.HW_INT_W(HW), .COUNT_DIV(DIV), .TLB_ENTRIES(16), .PRID_VAL(PRID)) dut (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .raddr_i(raddr),
    .rdata_o(rdata_o), .hw_int_i(hw_int), .exc_valid_i(exc_valid), .exc_code_i(exc_code),
    .exc_pc_i(exc_pc), .exc_bd_i(exc_bd), .exc_badvaddr_i(exc_badvaddr), .eret_i(eret),
    .tlbp_i(tlbp), .tlbp_hit_i(tlbp_hit), .tlbp_idx_i(tlbp_idx), .tlbr_i(tlbr),
    .tlbr_hi_i(tlbr_hi), .tlbr_lo0_i(tlbr_lo0), .tlbr_lo1_i(tlbr_lo1),
    .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .index_o(index_o),
    .entryhi_o(entryhi_o), .entrylo0_o(entrylo0_o), .entrylo1_o(entrylo1_o),
    .timer_int_o(timer_int_o), .int_req_o(int_req_o)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural state of the model.
  logic [31:0]     m_status, m_epc, m_bad, m_count, m_compare, m_hi, m_lo0, m_lo1;
  logic            m_bd, m_ti, m_fresh, m_p;
  logic [4:0]      m_excode;
  logic [1:0]      m_swip;
  logic [5:0]      m_hwip;
  logic [IDXW-1:0] m_idx;
  int              m_ticks;

  task automatic model_reset();
    m_status = 0; m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0;
    m_hi = 0; m_lo0 = 0; m_lo1 = 0; m_bd = 0; m_ti = 0; m_fresh = 0; m_p = 0;
    m_excode = 0; m_swip = 0; m_hwip = 0; m_idx = 0; m_ticks = 0;
  endtask

  function automatic logic [7:0] m_ip();
    return {m_hwip[5] | m_ti, m_hwip[4:0], m_swip};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_excode, 2'd0};
  endfunction

  function automatic logic [31:0] m_index();
    return {m_p, 27'd0, m_idx};
  endfunction

  function automatic logic m_intreq();
    return m_status[0] && !m_status[1] && ((m_ip() & m_status[15:8]) != 8'd0);
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a);
    case (a)
      5'd0:  return m_index();
      5'd2:  return m_lo0;
      5'd3:  return m_lo1;
      5'd8:  return m_bad;
      5'd9:  return m_count;
      5'd10: return m_hi;
      5'd11: return m_compare;
      5'd12: return m_status | 32'h0040_0000;
      5'd13: return m_cause();
      5'd14: return m_epc;
      5'd15: return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_next();
    logic        old_exl, old_fresh;
    logic [31:0] old_count;
    if (!rst) begin
      model_reset();
      return;
    end
    old_exl = m_status[1]; old_fresh = m_fresh; old_count = m_count;
    if (we && waddr == 9) begin
      m_count = wdata; m_ticks = 0; m_fresh = 0;
    end else if (m_ticks == DIV - 1) begin
      m_count = m_count + 1; m_ticks = 0; m_fresh = 1;
    end else begin
      m_ticks++; m_fresh = 0;
    end
    if (we && waddr == 11) begin
      m_compare = wdata; m_ti = 0;
    end else if (old_fresh && old_count == m_compare) begin
      m_ti = 1;
    end
    m_hwip = 6'(hw_int);
    if (we && waddr == 12) m_status = wdata & 32'h0000_FF03;
    if (we && waddr == 13) m_swip = wdata[9:8];
    if (we && waddr == 14) m_epc = wdata;
    if (we && waddr == 0)  m_idx = wdata[IDXW-1:0];
    if (we && waddr == 10) m_hi  = wdata & 32'hFFFF_E0FF;
    if (we && waddr == 2)  m_lo0 = wdata & 32'h03FF_FFFF;
    if (we && waddr == 3)  m_lo1 = wdata & 32'h03FF_FFFF;
    if (tlbp) begin
      m_p = !tlbp_hit;
      if (tlbp_hit) m_idx = tlbp_idx;
    end
    if (tlbr) begin
      m_hi = tlbr_hi & 32'hFFFF_E0FF; m_lo0 = tlbr_lo0 & 32'h03FF_FFFF; m_lo1 = tlbr_lo1 & 32'h03FF_FFFF;
    end
    if (eret) m_status[1] = 0;
    if (exc_valid) begin
      m_status[1] = 1;
      m_excode = exc_code;
      if (!old_exl) begin
        m_bd = exc_bd;
        m_epc = exc_bd ? exc_pc - 32'd4 : exc_pc;
      end
      if (exc_code >= 1 && exc_code <= 5) m_bad = exc_badvaddr;
    end
  endtask

  // Called just after a falling edge with the cycle's inputs already driven.
  task automatic tick();
    #1;
    check("rdata", rdata_o, rst ? mread(raddr) : 32'd0);
    model_next();
    @(posedge clk);
    #1;
    check("status", status_o, m_status | 32'h0040_0000);
    check("cause", cause_o, m_cause());
    check("epc", epc_o, m_epc);
    check("index", index_o, m_index());
    check("entryhi", entryhi_o, m_hi);
    check("entrylo0", entrylo0_o, m_lo0);
    check("entrylo1", entrylo1_o, m_lo1);
    check("timer_int", 32'(timer_int_o), 32'(m_ti));
    check("int_req", 32'(int_req_o), 32'(m_intreq()));
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; waddr = 0; wdata = 0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0;
    exc_badvaddr = 0; eret = 0; tlbp = 0; tlbp_hit = 0; tlbp_idx = 0; tlbr = 0;
    tlbr_hi = 0; tlbr_lo0 = 0; tlbr_lo1 = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); we = 1; waddr = a; wdata = d; tick(); idle();
  endtask

  task automatic exception(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic [31:0] bva);
    idle(); exc_valid = 1; exc_code = code; exc_pc = pc; exc_bd = bd; exc_badvaddr = bva;
    tick(); idle();
  endtask

  logic [4:0] addr_pool [12] = '{5'd0, 5'd2, 5'd3, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
                                 5'd13, 5'd14, 5'd15, 5'd20};

  initial begin
    model_reset();
    idle(); raddr = 0; hw_int = 0; rst = 0;
    @(negedge clk);
    tick();
    rst = 1;
    for (int a = 0; a < 32; a++) begin
      raddr = 5'(a);
      #0.1;
      check("reset_read", rdata_o, (a == 12) ? 32'h0040_0000 : (a == 15) ? PRID : 32'd0);
    end
    check("reset_timer_int", 32'(timer_int_o), 32'd0);
    check("reset_int_req", 32'(int_req_o), 32'd0);

    raddr = 5'd9;
    mtc0(5'd11, 32'd5);
    mtc0(5'd9, 32'd0);
    repeat (10) tick();
    check("count_at_10", rdata_o, 32'd5);
    check("ti_not_yet", 32'(timer_int_o), 32'd0);
    tick();
    check("ti_set", 32'(timer_int_o), 32'd1);
    check("cause_ti", 32'(cause_o[30]), 32'd1);
    mtc0(5'd11, 32'd1000);
    check("ti_cleared", 32'(timer_int_o), 32'd0);

    mtc0(5'd12, 32'h0000_FF01);
    hw_int = 6'b000010;
    tick();
    check("hw_int_req", 32'(int_req_o), 32'd1);
    exception(5'd0, 32'h8000_0040, 1'b0, 32'h0);
    check("exc_int_req", 32'(int_req_o), 32'd0);
    check("exc_exl", 32'(status_o[1]), 32'd1);
    eret = 1; tick(); idle();
    check("eret_int_req", 32'(int_req_o), 32'd1);
    hw_int = 0;

    raddr = 5'd8;
    exception(5'd4, 32'hBFC0_0104, 1'b1, 32'h1234_5677);
    check("bd_epc", epc_o, 32'hBFC0_0100);
    check("bd_bit", 32'(cause_o[31]), 32'd1);
    check("bd_code", 32'(cause_o[6:2]), 32'd4);
    check("badvaddr", rdata_o, 32'h1234_5677);
    exception(5'd10, 32'h0000_2000, 1'b0, 32'hFFFF_0000);
    check("nest_epc", epc_o, 32'hBFC0_0100);
    check("nest_bd", 32'(cause_o[31]), 32'd1);
    check("nest_code", 32'(cause_o[6:2]), 32'd10);
    check("nest_badvaddr", rdata_o, 32'h1234_5677);

    eret = 1; tick(); idle();
    we = 1; waddr = 5'd12; wdata = 32'd0; exc_valid = 1; exc_code = 5'd8; exc_pc = 32'h100;
    tick(); idle();
    check("prio_status", status_o, 32'h0040_0002);

    tlbp = 1; tlbp_hit = 0; tick(); idle();
    check("tlbp_miss", index_o, 32'h8000_0000);
    tlbp = 1; tlbp_hit = 1; tlbp_idx = 4'd3; tick(); idle();
    check("tlbp_hit", index_o, 32'd3);
    tlbr = 1; tlbr_hi = 32'hFFFF_FFFF; tlbr_lo0 = 32'hFFFF_FFFF; tlbr_lo1 = 32'hA5A5_A5A5;
    tick(); idle();
    check("tlbr_lo0", entrylo0_o, 32'h03FF_FFFF);
    check("tlbr_hi", entryhi_o, 32'hFFFF_E0FF);

    for (int i = 0; i < 800; i++) begin
      idle();
      rst = ($urandom_range(0, 199) != 0);
      we = ($urandom_range(0, 9) < 3);
      waddr = addr_pool[$urandom_range(0, 11)];
      wdata = $urandom;
      if (waddr == 11) wdata = m_count + 32'($urandom_range(0, 12));
      if (waddr == 9 && $urandom_range(0, 1) == 1) wdata = 32'hFFFF_FFF8;
      raddr = 5'($urandom);
      if ($urandom_range(0, 9) == 0) hw_int = 6'($urandom);
      exc_valid = ($urandom_range(0, 19) == 0);
      exc_code = 5'($urandom_range(0, 12));
      exc_pc = $urandom; exc_bd = 1'($urandom); exc_badvaddr = $urandom;
      eret = ($urandom_range(0, 19) == 0);
      tlbp = ($urandom_range(0, 19) == 0);
      tlbp_hit = 1'($urandom); tlbp_idx = 4'($urandom);
      tlbr = ($urandom_range(0, 19) == 0);
      tlbr_hi = $urandom; tlbr_lo0 = $urandom; tlbr_lo1 = $urandom;
      tick();
    end

    idle(); rst = 1;
    mtc0(5'd14, 32'h1111_2222);
    rst = 0; we = 1; waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    exc_valid = 1; exc_code = 5'd4; exc_pc = 32'h4000; exc_badvaddr = 32'h77;
    tick(); idle();
    check("rst_epc", epc_o, 32'd0);
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_cause", cause_o, 32'd0);
    rst = 1;
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
